// File: rtl/command_uart_tx.sv
// Command UART transmitter: packs mode/drive flags into {mode, seq, dir} and sends it 8N1
// whenever the command changes, when the heartbeat gap expires, and once after reset.
//
// state | meaning
// IDLE  | line high, waiting for a changed command, heartbeat timeout or post-reset send
// START | start bit (tx=0) for one bit time
// DATA  | eight data bits, LSB first, one bit time each
// STOP  | stop bit (tx=1) for one bit time, sent pulses on its last clock
module command_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int HEARTBEAT_MS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       manual_on,
  input  logic       auto_on,
  input  logic       w,
  input  logic       s,
  input  logic       a,
  input  logic       d,
  input  logic       wa,
  input  logic       wd,
  input  logic       as,
  input  logic       ds,
  input  logic       stop,
  output logic       tx,
  output logic       busy,
  output logic [7:0] cmd_code,
  output logic       sent
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HB_CLKS      = HEARTBEAT_MS * (CLK_FREQ / 1000);
  localparam int BIT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HB_W         = (HB_CLKS > 1) ? $clog2(HB_CLKS) : 1;
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [7:0]       dir_flags;
  logic [1:0]       mode_in;
  logic [3:0]       dir_in;
  logic [5:0]       next_cmd;
  logic [5:0]       last_cmd;
  logic             next_valid;
  logic             send_flag;
  logic [1:0]       seq;
  logic [HB_W-1:0]  hb_cnt;
  logic [BIT_W-1:0] bit_timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_done;
  logic             start_req;
  logic             frame_start;

  assign dir_flags = {ds, as, wd, wa, d, a, s, w};

  always_comb begin
    mode_in = 2'b00;
    if (manual_on && !auto_on)
      mode_in = 2'b01;
    else if (auto_on && !manual_on)
      mode_in = 2'b10;
    dir_in = 4'd0;
    if (!stop && (mode_in != 2'b00) && $onehot(dir_flags)) begin
      for (int i = 0; i < 8; i++)
        if (dir_flags[i]) dir_in = 4'(i + 1);
    end
  end

  // next_valid holds off the first compare until the inputs have been sampled once after reset
  assign bit_done    = (bit_timer == '0);
  assign start_req   = next_valid && ((next_cmd != last_cmd) || (hb_cnt == HB_LAST) || send_flag);
  assign frame_start = (state == IDLE) && start_req;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_req) state_nx = START;
      START:   if (bit_done) state_nx = DATA;
      DATA:    if (bit_done && (bit_idx == 3'd7)) state_nx = STOP;
      STOP:    if (bit_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    sent = 1'b0;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      STOP:    sent = bit_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_cmd   <= '0;
      next_valid <= 1'b0;
      last_cmd   <= '0;
      send_flag  <= 1'b1;
      seq        <= 2'd0;
      hb_cnt     <= '0;
      bit_timer  <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      cmd_code   <= 8'h00;
      busy       <= 1'b0;
    end else begin
      next_cmd   <= {mode_in, dir_in};
      next_valid <= 1'b1;
      busy       <= (state_nx != IDLE);

      if (frame_start)
        hb_cnt <= '0;
      else if (hb_cnt != HB_LAST)
        hb_cnt <= hb_cnt + HB_W'(1);

      if (frame_start) begin
        shreg     <= {next_cmd[5:4], seq, next_cmd[3:0]};
        cmd_code  <= {next_cmd[5:4], seq, next_cmd[3:0]};
        last_cmd  <= next_cmd;
        send_flag <= 1'b0;
      end

      if (state_nx != state)
        bit_timer <= BIT_LOAD;
      else if (state != IDLE)
        bit_timer <= bit_done ? BIT_LOAD : bit_timer - BIT_W'(1);

      // bit_idx wraps back to 0 on the last data bit, ready for the next frame
      if ((state == DATA) && bit_done) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end

      if (sent)
        seq <= seq + 2'd1;
    end
  end

endmodule

// File: tb/tb_command_uart_tx.sv
// Bench for command_uart_tx: decodes the serial line like a UART receiver and checks
// each frame's timing and byte against a rule-level model of what should be sent.
module tb_command_uart_tx;

  localparam int CLK_FREQ     = 1000000;
  localparam int BAUD         = 100000;
  localparam int HEARTBEAT_MS = 1;
  localparam int CPB          = CLK_FREQ / BAUD;
  localparam int HB           = HEARTBEAT_MS * (CLK_FREQ / 1000);
  localparam int FRAME        = 10 * CPB;

  // flag vector layout: {manual, auto, stop, ds, as, wd, wa, d, a, s, w}
  localparam logic [10:0] F_MAN  = 11'h400;
  localparam logic [10:0] F_AUTO = 11'h200;
  localparam logic [10:0] F_STOP = 11'h100;
  localparam logic [10:0] F_W    = 11'h001;
  localparam logic [10:0] F_S    = 11'h002;
  localparam logic [10:0] F_A    = 11'h004;
  localparam logic [10:0] F_WD   = 11'h020;
  localparam logic [10:0] F_DS   = 11'h080;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] flags = '0;
  logic        tx, busy, sent;
  logic [7:0]  cmd_code;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  int          exp_seq;
  logic [5:0]  last_md;
  int          last_start;

  bit          r_got, r_glitch, r_busybad, r_codebad;
  int          r_start, r_nsent, r_sentpos;
  logic [9:0]  r_bits;
  logic [7:0]  r_byte, r_code;
  logic        r_busy_after, r_sent_after;

  command_uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .HEARTBEAT_MS(HEARTBEAT_MS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .manual_on(flags[10]),
    .auto_on(flags[9]),
    .w(flags[0]),
    .s(flags[1]),
    .a(flags[2]),
    .d(flags[3]),
    .wa(flags[4]),
    .wd(flags[5]),
    .as(flags[6]),
    .ds(flags[7]),
    .stop(flags[8]),
    .tx(tx),
    .busy(busy),
    .cmd_code(cmd_code),
    .sent(sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] model_md(input logic [10:0] f);
    int n, dir;
    logic [1:0] mode;
    n = 0;
    dir = 0;
    mode = (f[10] && !f[9]) ? 2'b01 : (f[9] && !f[10]) ? 2'b10 : 2'b00;
    for (int i = 0; i < 8; i++)
      if (f[i]) begin
        n++;
        dir = i + 1;
      end
    if (f[8] || n != 1 || mode == 2'b00) dir = 0;
    return {mode, 4'(dir)};
  endfunction

  function automatic logic [7:0] model_byte(input logic [5:0] md, input int sq);
    return {md[5:4], 2'(sq), md[3:0]};
  endfunction

  function automatic logic [10:0] rand_flags();
    logic [10:0] f;
    int m, k;
    f = '0;
    m = int'($urandom_range(0, 3));
    f[10] = (m == 1 || m == 3);
    f[9]  = (m == 2 || m == 3);
    k = int'($urandom_range(0, 4));
    if (k >= 1) f[$urandom_range(0, 7)] = 1'b1;
    if (k == 4) f[$urandom_range(0, 7)] = 1'b1;
    f[8] = ($urandom_range(0, 7) == 0);
    return f;
  endfunction

  // expected start cycle for a command applied now while idle
  function automatic int expect_start(input logic [5:0] md);
    return (md != last_md) ? cyc + 2 : last_start + HB;
  endfunction

  function automatic bit frame_ok();
    return !r_glitch && r_bits[0] === 1'b0 && r_bits[9] === 1'b1 && r_nsent == 1 &&
           r_sentpos == FRAME - 1 && !r_busybad && !r_codebad && r_code === r_byte &&
           r_busy_after === 1'b0 && r_sent_after === 1'b0;
  endfunction

  function automatic string shape_str();
    return $sformatf("bits=%b nsent=%0d sentpos=%0d glitch=%0d busybad=%0d code=%h codebad=%0d busy_after=%b sent_after=%b; required start 0, stop 1, one sent at %0d, busy high, cmd_code=%h stable",
                     r_bits, r_nsent, r_sentpos, r_glitch, r_busybad, r_code, r_codebad,
                     r_busy_after, r_sent_after, FRAME - 1, r_byte);
  endfunction

  // Waits (bounded) for a start bit, then records one whole frame; a1/a2 apply flag changes mid-frame.
  task automatic recv(input int max_wait, input int a1_at, input logic [10:0] a1_val,
                      input int a2_at, input logic [10:0] a2_val);
    int waited;
    waited = 0;
    r_got = 0; r_glitch = 0; r_busybad = 0; r_codebad = 0;
    r_nsent = 0; r_sentpos = -1; r_bits = '1; r_byte = '0; r_code = '0;
    r_busy_after = 1'bx; r_sent_after = 1'bx; r_start = -1;
    while (tx !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) return;
    r_got = 1;
    r_start = cyc;
    for (int i = 0; i < FRAME; i++) begin
      if (i == a1_at) flags = a1_val;
      if (i == a2_at) flags = a2_val;
      if (i % CPB == 0) r_bits[i / CPB] = tx;
      else if (tx !== r_bits[i / CPB]) r_glitch = 1;
      if (sent === 1'b1) begin
        r_nsent++;
        r_sentpos = i;
      end
      if (busy !== 1'b1) r_busybad = 1;
      if (i == 0) r_code = cmd_code;
      else if (cmd_code !== r_code) r_codebad = 1;
      @(negedge clk);
    end
    r_busy_after = busy;
    r_sent_after = sent;
    r_byte = r_bits[8:1];
  endtask

  task automatic commit(input logic [5:0] md);
    exp_seq = (exp_seq + 1) % 4;
    last_md = md;
    last_start = r_start;
  endtask

  task automatic test_reset();
    int es;
    logic [7:0] eb;
    reset = 1'b1;
    flags = '0;
    repeat (3) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset tx: got %b, required 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b, required 0", busy); end
    vectors++; if (sent !== 1'b0) begin miscompares++; $display("FAIL reset sent: got %b, required 0", sent); end
    vectors++; if (cmd_code !== 8'h00) begin miscompares++; $display("FAIL reset cmd_code: got %h, required 00", cmd_code); end
    reset = 1'b0;
    exp_seq = 0;
    last_md = '0;
    es = cyc + 2;
    eb = model_byte(6'd0, exp_seq);
    recv(5, -1, '0, -1, '0);
    vectors++;
    if (!r_got) begin
      miscompares++; $display("FAIL first_frame start: no start bit detected, required at cycle %0d", es);
    end else begin
      vectors++; if (r_start !== es) begin miscompares++; $display("FAIL first_frame latency: start %0d, required %0d", r_start, es); end
      vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL first_frame byte: got %h, required %h", r_byte, eb); end
      vectors++; if (frame_ok() !== 1'b1) begin miscompares++; $display("FAIL first_frame shape: %s", shape_str()); end
    end
    commit(6'd0);
  endtask

  task automatic test_manual_w();
    int es;
    logic [5:0] md;
    logic [7:0] eb;
    repeat (2) @(negedge clk);
    flags = F_MAN | F_W;
    md = model_md(flags);
    es = expect_start(md);
    eb = model_byte(md, exp_seq);
    recv(es - cyc + 3, -1, '0, -1, '0);
    vectors++;
    if (!r_got) begin
      miscompares++; $display("FAIL manual_w start: no start bit detected, required at cycle %0d", es);
    end else begin
      vectors++; if (r_start !== es) begin miscompares++; $display("FAIL manual_w latency: start %0d, required %0d", r_start, es); end
      vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL manual_w byte: got %h, required %h", r_byte, eb); end
      vectors++; if (frame_ok() !== 1'b1) begin miscompares++; $display("FAIL manual_w shape: %s", shape_str()); end
    end
    commit(md);
  endtask

  task automatic test_mid_frame_change();
    int es;
    logic [5:0] md1, md2;
    logic [7:0] eb;
    flags = F_MAN | F_S;
    md1 = model_md(flags);
    md2 = model_md(F_AUTO | F_DS);
    es = expect_start(md1);
    eb = model_byte(md1, exp_seq);
    recv(es - cyc + 3, 4 * CPB, F_AUTO | F_DS, -1, '0);
    vectors++;
    if (!r_got) begin
      miscompares++; $display("FAIL midframe_cur start: no start bit detected, required at cycle %0d", es);
    end else begin
      vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL midframe_cur byte: got %h, required %h", r_byte, eb); end
      vectors++; if (frame_ok() !== 1'b1) begin miscompares++; $display("FAIL midframe_cur shape: %s", shape_str()); end
    end
    commit(md1);
    es = last_start + FRAME + 1;
    eb = model_byte(md2, exp_seq);
    recv(es - cyc + 3, -1, '0, -1, '0);
    vectors++;
    if (!r_got) begin
      miscompares++; $display("FAIL midframe_next start: no start bit detected, required at cycle %0d", es);
    end else begin
      vectors++; if (r_start !== es) begin miscompares++; $display("FAIL midframe_next gap: start %0d, required %0d", r_start, es); end
      vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL midframe_next byte: got %h, required %h", r_byte, eb); end
    end
    commit(md2);
  endtask

  task automatic test_invalid_combos();
    logic [10:0] tbl [3];
    int es;
    logic [5:0] md;
    logic [7:0] eb;
    tbl[0] = F_MAN | F_W | F_A;
    tbl[1] = F_MAN | F_AUTO | F_W;
    tbl[2] = F_MAN | F_W | F_STOP;
    for (int k = 0; k < 3; k++) begin
      flags = tbl[k];
      md = model_md(flags);
      es = expect_start(md);
      eb = model_byte(md, exp_seq);
      recv(es - cyc + 3, -1, '0, -1, '0);
      vectors++;
      if (!r_got) begin
        miscompares++; $display("FAIL invalid[%0d] start: no start bit detected, required at cycle %0d", k, es);
      end else begin
        vectors++; if (r_start !== es) begin miscompares++; $display("FAIL invalid[%0d] latency: start %0d, required %0d", k, r_start, es); end
        vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL invalid[%0d] byte: got %h, required %h", k, r_byte, eb); end
      end
      commit(md);
    end
  endtask

  task automatic test_revert_and_heartbeat();
    int es;
    logic [5:0] md;
    logic [7:0] eb;
    flags = F_MAN | F_A;
    md = model_md(flags);
    es = expect_start(md);
    eb = model_byte(md, exp_seq);
    recv(es - cyc + 3, 2 * CPB, F_AUTO | F_W, 6 * CPB, F_MAN | F_A);
    vectors++;
    if (!r_got) begin
      miscompares++; $display("FAIL revert_cur start: no start bit detected, required at cycle %0d", es);
    end else begin
      vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL revert_cur byte: got %h, required %h", r_byte, eb); end
    end
    commit(md);
    for (int k = 0; k < 4; k++) begin
      es = last_start + HB;
      eb = model_byte(md, exp_seq);
      recv(es - cyc + 3, -1, '0, -1, '0);
      vectors++;
      if (!r_got) begin
        miscompares++; $display("FAIL heartbeat[%0d] start: no start bit detected, required at cycle %0d", k, es);
      end else begin
        vectors++; if (r_start !== es) begin miscompares++; $display("FAIL heartbeat[%0d] period: start %0d, required %0d", k, r_start, es); end
        vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL heartbeat[%0d] byte: got %h, required %h", k, r_byte, eb); end
        vectors++; if (frame_ok() !== 1'b1) begin miscompares++; $display("FAIL heartbeat[%0d] shape: %s", k, shape_str()); end
      end
      commit(md);
    end
  endtask

  task automatic test_random();
    int es;
    logic [5:0] md;
    logic [7:0] eb;
    logic [10:0] nf;
    for (int v = 0; v < 16; v++) begin
      nf = rand_flags();
      flags = nf;
      md = model_md(nf);
      es = expect_start(md);
      eb = model_byte(md, exp_seq);
      recv(es - cyc + 3, -1, '0, -1, '0);
      vectors++;
      if (!r_got) begin
        miscompares++; $display("FAIL random[%0d] start: no start bit detected for flags %b, required at cycle %0d", v, nf, es);
      end else begin
        vectors++; if (r_start !== es) begin miscompares++; $display("FAIL random[%0d] timing: flags %b start %0d, required %0d", v, nf, r_start, es); end
        vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL random[%0d] byte: flags %b got %h, required %h", v, nf, r_byte, eb); end
        vectors++; if (frame_ok() !== 1'b1) begin miscompares++; $display("FAIL random[%0d] shape: %s", v, shape_str()); end
      end
      commit(md);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    int es, waited;
    bit saw_sent;
    logic [5:0] md;
    logic [7:0] eb;
    flags = F_AUTO | F_WD;
    md = model_md(flags);
    es = expect_start(md);
    waited = 0;
    while (tx !== 1'b0 && waited < es - cyc + 3) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (tx !== 1'b0) begin miscompares++; $display("FAIL rst_mid start: no start bit detected, required at cycle %0d", es); end
    saw_sent = 0;
    repeat (5 * CPB + 3) begin
      if (sent === 1'b1) saw_sent = 1;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid tx: got %b, required 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid busy: got %b, required 0", busy); end
    vectors++; if ((saw_sent | sent) !== 1'b0) begin miscompares++; $display("FAIL rst_mid sent: got %b, required 0", saw_sent | sent); end
    repeat (2) @(negedge clk);
    vectors++; if (cmd_code !== 8'h00) begin miscompares++; $display("FAIL rst_mid cmd_code: got %h, required 00", cmd_code); end
    reset = 1'b0;
    exp_seq = 0;
    last_md = '0;
    es = cyc + 2;
    eb = model_byte(md, exp_seq);
    recv(5, -1, '0, -1, '0);
    vectors++;
    if (!r_got) begin
      miscompares++; $display("FAIL rst_mid fresh start: no start bit detected, required at cycle %0d", es);
    end else begin
      vectors++; if (r_start !== es) begin miscompares++; $display("FAIL rst_mid fresh latency: start %0d, required %0d", r_start, es); end
      vectors++; if (r_byte !== eb) begin miscompares++; $display("FAIL rst_mid fresh byte: got %h, required %h", r_byte, eb); end
      vectors++; if (frame_ok() !== 1'b1) begin miscompares++; $display("FAIL rst_mid fresh shape: %s", shape_str()); end
    end
    commit(md);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_manual_w();
    test_mid_frame_change();
    test_invalid_combos();
    test_revert_and_heartbeat();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
